logic_unit_selftest_seq: RTL and testbench

//  On-chip self-test sequencer for the lab1 switch->LED logic unit (8b in, led[3:0] checked).

---
 rtl/logic_unit_selftest_seq.sv | 85 ++++++++
 tb/tb_logic_unit_selftest_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_selftest_seq.sv
// logic_unit_selftest_seq: sweeps every switch pattern through the logic unit and checks led[3:0] against golden functions.
// Define SELFTEST_STOP_ON_FAIL_EN to halt in DONE on the first mismatching pattern.
module logic_unit_selftest_seq #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] PATTERN_LAST  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] pattern,
    input  logic [7:0] resp,
    output logic       busy,
    output logic       done,
    output logic [8:0] error_count,
    output logic       fail_seen,
    output logic [7:0] first_fail
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
    state_t state;
    logic [CW-1:0] ctr;
    logic [3:0] golden;
    logic mismatch, stop, unused_resp;
    always_comb begin
        golden[0] = pattern[0] & pattern[1];
        golden[1] = pattern[2] & ~pattern[3];
        golden[2] = ~^pattern;
        golden[3] = pattern[4] ? golden[0] : golden[1];
    end
    assign mismatch    = resp[3:0] != golden;
    assign unused_resp = ^resp[7:4];
`ifdef SELFTEST_STOP_ON_FAIL_EN
    assign stop = mismatch;
`else
    assign stop = 1'b0;
`endif
    // Compare before increment so PATTERN_LAST=FF ends without wrapping to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pattern     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error_count <= '0;
            fail_seen   <= 1'b0;
            first_fail  <= '0;
            ctr         <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state       <= APPLY;
                    pattern     <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    error_count <= '0;
                    fail_seen   <= 1'b0;
                    first_fail  <= '0;
                end
                APPLY: begin
                    ctr   <= CW'(SETTLE_CYCLES - 1);
                    state <= SETTLE;
                end
                SETTLE: if (ctr == '0) state <= CHECK; else ctr <= ctr - 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        error_count <= error_count + 1'b1;
                        if (!fail_seen) begin
                            fail_seen  <= 1'b1;
                            first_fail <= pattern;
                        end
                    end
                    if (pattern == PATTERN_LAST || stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pattern <= pattern + 1'b1;
                        state   <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_unit_selftest_seq.sv
// tb_logic_unit_selftest_seq: drives the self-test sequencer against a faultable logic-unit model
// and checks it against a sweep-timeline model plus hand-computed results.
module tb_logic_unit_selftest_seq;
    localparam int S = 2;
    localparam int P = S + 2;
    localparam int N = 256;
`ifdef SELFTEST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, start, start0;
    logic [7:0] pattern, resp, pattern0, resp0, first_fail, first_fail0;
    logic busy, done, fail_seen, busy0, done0, fail_seen0;
    logic [8:0] error_count, error_count0;
    int mode, mode0;
    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    logic_unit_selftest_seq #(.SETTLE_CYCLES(S), .PATTERN_LAST(8'hFF)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .resp(resp),
        .busy(busy), .done(done), .error_count(error_count),
        .fail_seen(fail_seen), .first_fail(first_fail));
    logic_unit_selftest_seq #(.SETTLE_CYCLES(S), .PATTERN_LAST(8'h00)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pattern(pattern0), .resp(resp0),
        .busy(busy0), .done(done0), .error_count(error_count0),
        .fail_seen(fail_seen0), .first_fail(first_fail0));

    function automatic logic [3:0] gold(input logic [7:0] p);
        logic a, b;
        a = p[0] && p[1];
        b = p[2] && !p[3];
        return {p[4] ? a : b, $countones(p) % 2 == 0, b, a};
    endfunction
    // Logic unit under test: 0 good, 1 led0 stuck 0, 2 led2 inverted, 3 led1 stuck 1.
    function automatic logic [3:0] unit(input logic [7:0] p, input int md);
        logic [3:0] g;
        g = gold(p);
        if (md == 1) g[0] = 1'b0;
        if (md == 2) g[2] = ~g[2];
        if (md == 3) g[1] = 1'b1;
        return g;
    endfunction
    assign resp  = {~pattern[7:4], unit(pattern, mode)};
    assign resp0 = {pattern0[7:4], unit(pattern0, mode0)};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position in the sweep is the number of clocks since start was accepted.
    int m_k, m_err;
    bit m_run, m_done, m_fs;
    logic [7:0] m_pat, m_ff;
    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_k = 0; m_err = 0; m_fs = 0; m_ff = 0; m_pat = 0;
        end else if (!m_run && start) begin
            m_run = 1; m_done = 0; m_k = 0; m_err = 0; m_fs = 0; m_ff = 0; m_pat = 0;
        end else if (m_run) begin
            if (m_k % P == S + 1 && unit(m_pat, mode) != gold(m_pat)) begin
                m_err++;
                if (!m_fs) begin m_fs = 1; m_ff = m_pat; end
                if (STOP) begin m_run = 0; m_done = 1; end
            end
            if (m_run) begin
                m_k++;
                if (m_k == N * P) begin m_run = 0; m_done = 1; end
                else m_pat = 8'(m_k / P);
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("pattern", pattern, m_pat);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("error_count", error_count, m_err);
        chk("fail_seen", fail_seen, m_fs);
        if (m_fs) chk("first_fail", first_fail, m_ff);
    end

    task automatic sweep(input int poke, output int n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
            start = (n == poke);
        end
        start = 1'b0;
        chk("sweep_done", done, 1);
    endtask

    task automatic sweep0(output int n);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sweep0_done", done0, 1);
    endtask

    int n;
    initial begin
        rst = 1'b1; start = 1'b0; start0 = 1'b0; mode = 0; mode0 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_pattern", pattern, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errors", error_count, 0);
        // Good unit, plus a start pulse mid-sweep that must not restart it.
        sweep(100, n);
        chk("good_len", n, 1024);
        chk("good_errors", error_count, 0);
        chk("good_fail_seen", fail_seen, 0);
        chk("good_last_pattern", pattern, 8'hFF);
`ifdef SELFTEST_STOP_ON_FAIL_EN
        mode = 3;
        sweep(0, n);
        chk("stop_len", n, P);
        chk("stop_pattern", pattern, 8'h00);
        chk("stop_errors", error_count, 1);
        chk("stop_first_fail", first_fail, 8'h00);
`else
        mode = 1;
        sweep(0, n);
        chk("stuck0_errors", error_count, 64);
        chk("stuck0_first_fail", first_fail, 8'h03);
        chk("stuck0_fail_seen", fail_seen, 1);
        mode = 2;
        sweep(0, n);
        chk("inv2_errors", error_count, 256);
        chk("inv2_first_fail", first_fail, 8'h00);
        chk("inv2_len", n, 1024);
`endif
        // Reset mid-SETTLE of pattern 0x40.
        mode = STOP ? 0 : 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (64 * P + 1) @(negedge clk);
        chk("mid_pattern", pattern, 8'h40);
        chk("mid_errors", error_count, STOP ? 0 : 64);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pattern", pattern, 0);
        chk("rst_mid_errors", error_count, 0);
        chk("rst_mid_fail_seen", fail_seen, 0);
        // rst and start together: rst wins.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        @(negedge clk);
        chk("rst_start_idle", busy, 0);
        // Single-pattern sweep: done S+2 clocks after the accepting edge.
        mode0 = 2;
        sweep0(n);
        chk("single_len", n, S + 2);
        chk("single_errors", error_count0, 1);
        chk("single_first_fail", first_fail0, 8'h00);
        chk("single_fail_seen", fail_seen0, 1);
        mode0 = 0;
        @(negedge clk);
        sweep0(n);
        chk("rerun_len", n, S + 2);
        chk("rerun_errors", error_count0, 0);
        chk("rerun_fail_seen", fail_seen0, 0);
        chk("rerun_pattern", pattern0, 0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
